// File: rtl/flash_cmd_seq.sv
// flash_cmd_seq: SPI NOR (25-series) erase/program sequencer: WREN, command frame, RDSR polling
// Ports:
//   sys_clk, sys_rst     clock and synchronous active-high reset
//   start, op, addr,     request strobe (IDLE only), op 00 SE / 01 BE / 10 PP / 11 reserved,
//   wdata                24-bit byte address and program data, latched on acceptance
//   busy, done, err      request in progress, one-cycle completion pulse, error valid with done
//   cs_n, sck, mosi,     SPI mode 0 at sys_clk/4, MSB first
//   miso
// Optional: define FLASH_WEL_CHECK_EN to read status after WREN and abort if WEL is clear.
module flash_cmd_seq #(
    parameter int CS_GAP   = 32,
    parameter int POLL_MAX = 65535,
    parameter int POLL_W   = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [23:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cs_n,
    output logic        sck,
    output logic        mosi,
    input  logic        miso
);
    typedef enum logic [3:0] {IDLE, ARM, WREN, GAP1, WELRD, GAP4, CMD, GAP2, POLL, GAP3, DONE} state_t;
    state_t state, nxt_st;
    logic [1:0]  op_q;
    logic [23:0] addr_q;
    logic [7:0]  wdata_q;
    logic [38:0] tx;
    logic [7:0]  fb, cnt, nc, cmd_fb, nxt_fb;
    logic [15:0] gc;
    logic [POLL_W-1:0] pc;
    logic [39:0] cmd_tx, nxt_tx;
`ifdef FLASH_WEL_CHECK_EN
    logic [1:0] rx;
`else
    logic [0:0] rx;
`endif
    // frame payloads are left-aligned; fb is the number of bit cycles (4 per bit)
    always_comb begin
        cmd_tx = op_q == 2'b00 ? {8'hD8, addr_q, 8'h00} : op_q == 2'b01 ? {8'hC7, 32'h0} : {8'h02, addr_q, wdata_q};
        cmd_fb = op_q == 2'b00 ? 8'd128 : op_q == 2'b01 ? 8'd32 : 8'd160;
`ifdef FLASH_WEL_CHECK_EN
        nxt_st = state == ARM ? WREN : state == GAP1 ? WELRD : (state == GAP2 || state == GAP3) ? POLL : CMD;
`else
        nxt_st = state == ARM ? WREN : (state == GAP2 || state == GAP3) ? POLL : CMD;
`endif
        nxt_tx = nxt_st == WREN ? {8'h06, 32'h0} : nxt_st == CMD ? cmd_tx : {8'h05, 32'h0};
        nxt_fb = nxt_st == WREN ? 8'd32 : nxt_st == CMD ? cmd_fb : 8'd64;
        nc     = cnt + 8'd1;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cs_n    <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tx      <= '0;
            fb      <= '0;
            cnt     <= '0;
            gc      <= '0;
            pc      <= '0;
            rx      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_q    <= op;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    pc      <= '0;
                    busy    <= 1'b1;
                    state   <= ARM;
                end
                ARM: if (op_q == 2'b11) begin
                    state <= DONE;
                    done  <= 1'b1;
                    err   <= 1'b1;
                end else begin
                    state <= nxt_st;
                    cs_n  <= 1'b0;
                    mosi  <= nxt_tx[39];
                    tx    <= nxt_tx[38:0];
                    fb    <= nxt_fb;
                    cnt   <= '0;
                end
                WREN, WELRD, CMD, POLL: begin
                    if (cnt == fb + 8'd3) begin
                        cs_n <= 1'b1;
                        gc   <= '0;
                        if (state == WREN) state <= GAP1;
                        else if (state == CMD) state <= GAP2;
`ifdef FLASH_WEL_CHECK_EN
                        else if (state == WELRD) begin
                            state <= rx[1] ? GAP4 : DONE;
                            done  <= !rx[1];
                            err   <= !rx[1];
                        end
`endif
                        else begin
                            if (pc != POLL_W'(POLL_MAX)) pc <= pc + POLL_W'(1);
                            // rx[0] is WIP of the status byte just read
                            if (!rx[0] || pc >= POLL_W'(POLL_MAX - 1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                                err   <= rx[0];
                            end else state <= GAP3;
                        end
                    end else begin
                        cnt <= nc;
                        sck <= nc[1] && nc < fb;
                        if (nc[1:0] == 2'd0) begin
                            mosi <= nc < fb && tx[38];
                            tx   <= {tx[37:0], 1'b0};
                        end
                        // sample on the edge that raises sck
                        if (cnt[1:0] == 2'd1 && cnt < fb) begin
`ifdef FLASH_WEL_CHECK_EN
                            rx <= {rx[0], miso};
`else
                            rx <= miso;
`endif
                        end
                    end
                end
                GAP1, GAP2, GAP3, GAP4: if (gc == 16'(CS_GAP - 1)) begin
                    state <= nxt_st;
                    cs_n  <= 1'b0;
                    mosi  <= nxt_tx[39];
                    tx    <= nxt_tx[38:0];
                    fb    <= nxt_fb;
                    cnt   <= '0;
                end else gc <= gc + 16'd1;
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_cmd_seq.sv
// tb_flash_cmd_seq: directed bench with flash model and frame scoreboard for flash_cmd_seq
module tb_flash_cmd_seq;
    localparam int PMAX = 4;
    localparam int GAP  = 32;
    typedef struct {int nb; logic [39:0] d;} frm_t;
    logic sys_clk, sys_rst, start, miso;
    logic [1:0] op;
    logic [23:0] addr;
    logic [7:0] wdata;
    logic busy, done, err, cs_n, sck, mosi;
    frm_t exp_q[$];
    frm_t cur = '{nb: 0, d: 40'h0};
    int passes = 0, checks = 0, frames = 0, wip_n = 0, rd_idx = 0;
    int low_len = 0, high_len = 0, nb = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0, in_gap = 1'b0;
    logic [39:0] cap = '0;
    logic [7:0] cmd = '0, st = '0;

    flash_cmd_seq #(.CS_GAP(GAP), .POLL_MAX(PMAX), .POLL_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int n, input logic [39:0] d);
        exp_q.push_back('{nb: n, d: d});
    endtask

    // flash model and frame monitor, sampled on the falling clock edge
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            exp_q.delete();
            prev_cs = 1'b1;
            prev_sck = 1'b0;
            prev_mosi = 1'b0;
            in_gap = 1'b0;
            miso = 1'b0;
        end else begin
            if (!cs_n && prev_cs) begin
                if (in_gap) chk("gap_len", 64'(high_len), 64'(GAP));
                chk("frame_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else cur = '{nb: 0, d: 40'h0};
                low_len = 0;
                nb = 0;
                cap = '0;
                cmd = '0;
            end
            if (!cs_n) begin
                chk("sck_phase", 64'(sck), 64'(low_len % 4 >= 2 && low_len / 4 < cur.nb));
                if (low_len % 4 != 0) chk("mosi_stable", 64'(mosi), 64'(prev_mosi));
                if (low_len / 4 >= cur.nb) chk("mosi_tail", 64'(mosi), 64'(0));
                if (sck && !prev_sck) begin
                    cap = {cap[38:0], mosi};
                    nb++;
                    if (nb == 8) cmd = cap[7:0];
                end
                if (!sck && prev_sck && cmd == 8'h05 && nb >= 8 && nb < 16) begin
                    st = {6'd0, 1'b1, rd_idx < wip_n};
                    miso = st[3'(15 - nb)];
                end
                low_len++;
            end else begin
                chk("idle_sck", 64'(sck), 64'(0));
                chk("idle_mosi", 64'(mosi), 64'(0));
            end
            if (cs_n && !prev_cs) begin
                chk("frame_bits", 64'(nb), 64'(cur.nb));
                chk("frame_data", 64'(cap), 64'(cur.d));
                chk("frame_len", 64'(low_len), 64'(4 * cur.nb + 4));
                if (cmd == 8'h05) rd_idx++;
                in_gap = 1'b1;
                high_len = 0;
                miso = 1'b0;
                frames++;
            end
            if (cs_n) high_len++;
            if (!busy) in_gap = 1'b0;
            prev_cs = cs_n;
            prev_sck = sck;
            prev_mosi = mosi;
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [23:0] a, input logic [7:0] w, input int wn);
        int n;
        int np;
        logic exp_err;
        np = wn < PMAX ? wn + 1 : PMAX;
        exp_err = wn >= PMAX;
        push(8, 40'h06);
        push(o == 2'b00 ? 32 : o == 2'b01 ? 8 : 40,
             o == 2'b00 ? {8'h00, 8'hD8, a} : o == 2'b01 ? 40'hC7 : {8'h02, a, w});
        for (int i = 0; i < np; i++) push(16, 40'h0500);
        wip_n = wn;
        rd_idx = 0;
        @(negedge sys_clk);
        start = 1'b1;
        op = o;
        addr = a;
        wdata = w;
        @(negedge sys_clk);
        start = 1'b0;
        op = 2'($urandom);
        addr = 24'($urandom);
        wdata = 8'($urandom);
        chk("busy_after_start", 64'(busy), 64'(1));
        n = 0;
        while (!done && n < 5000) begin
            @(negedge sys_clk);
            n++;
            start = (n == 60);
        end
        chk("done_seen", 64'(done), 64'(1));
        chk("err", 64'(err), 64'(exp_err));
        chk("busy_in_done", 64'(busy), 64'(1));
        chk("frames_left", 64'(exp_q.size()), 64'(0));
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("done_after", 64'(done), 64'(0));
        chk("err_after", 64'(err), 64'(0));
        repeat (50) @(negedge sys_clk);
        chk("cs_idle", 64'(cs_n), 64'(1));
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int f0;
        sys_rst = 1'b1;
        start = 1'b0;
        op = '0;
        addr = '0;
        wdata = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_cs_n", 64'(cs_n), 64'(1));
        chk("rst_sck", 64'(sck), 64'(0));
        chk("rst_mosi", 64'(mosi), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        do_op(2'b01, 24'h000000, 8'h00, 3);
        do_op(2'b00, 24'h123456, 8'h00, 0);
        do_op(2'b10, 24'h000100, 8'hA5, 1);
        do_op(2'b01, 24'h000000, 8'h00, 100);
        // reserved op: done/err two cycles after the start cycle, no SPI frame
        @(negedge sys_clk);
        start = 1'b1;
        op = 2'b11;
        @(negedge sys_clk);
        start = 1'b0;
        chk("rsv_busy", 64'(busy), 64'(1));
        chk("rsv_done_early", 64'(done), 64'(0));
        @(negedge sys_clk);
        chk("rsv_done", 64'(done), 64'(1));
        chk("rsv_err", 64'(err), 64'(1));
        chk("rsv_cs_n", 64'(cs_n), 64'(1));
        @(negedge sys_clk);
        chk("rsv_done_clr", 64'(done), 64'(0));
        chk("rsv_busy_clr", 64'(busy), 64'(0));
        repeat (10) @(negedge sys_clk);
        // reset in the middle of the command frame
        push(8, 40'h06);
        push(40, {8'h02, 24'hABCDEF, 8'h3C});
        push(16, 40'h0500);
        wip_n = 0;
        rd_idx = 0;
        @(negedge sys_clk);
        start = 1'b1;
        op = 2'b10;
        addr = 24'hABCDEF;
        wdata = 8'h3C;
        @(negedge sys_clk);
        start = 1'b0;
        f0 = frames;
        n = 0;
        while (!(frames == f0 + 1 && !cs_n) && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("reach_cmd", 64'(frames == f0 + 1 && !cs_n), 64'(1));
        repeat (20) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("mid_rst_cs_n", 64'(cs_n), 64'(1));
        chk("mid_rst_sck", 64'(sck), 64'(0));
        chk("mid_rst_mosi", 64'(mosi), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        do_op(2'b10, 24'hABCDEF, 8'h3C, 2);
        repeat (10) @(negedge sys_clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
